mips_prog_loader: RTL and testbench

MIPS_PROG_LOADER -- requirements
Module: mips_prog_loader

---
 rtl/mips_prog_loader.sv | 124 ++++++++++++
 tb/tb_mips_prog_loader.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_prog_loader.sv
// Streams a program into instruction memory, pulses the CPU start, waits for halt,
// then dumps R0..R(DUMP_N-1). Writes land one cycle after acceptance; the dump stalls on out_ready.
module mips_prog_loader #(
  parameter int ADDR_W = 10,
  parameter int DUMP_N = 6
) (
  input  logic              clk1,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_data,
  input  logic              in_last,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_start,
  input  logic              cpu_halted,
  output logic [4:0]        reg_addr,
  input  logic [31:0]       reg_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_data,
  output logic              out_last,
  output logic              busy,
  output logic              err
);

  typedef enum logic [2:0] {IDLE, LOAD, START, RUN, DUMP} state_t;

  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;
  localparam logic [4:0]        LAST_IDX = 5'(DUMP_N - 1);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] waddr;
  logic              fin;
  logic [1:0]        run_cnt;
  logic [4:0]        idx;
  logic              acc;
  logic              wr_end;

  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // fin marks the LOAD cycle in which the final word is being written; START follows it.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    cpu_start = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_nxt = LOAD;
      end
      LOAD: begin
        in_ready = !fin;
        if (fin) state_nxt = START;
      end
      START: begin
        cpu_start = 1'b1;
        state_nxt = RUN;
      end
      RUN: begin
        if (run_cnt == 2'd2 && cpu_halted) state_nxt = DUMP;
      end
      DUMP: begin
        if (out_valid && out_ready && out_last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign acc      = in_valid && in_ready;
  assign waddr    = (state == IDLE) ? '0 : addr;
  assign wr_end   = in_last || (waddr == ADDR_MAX);
  assign reg_addr = idx;

  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      addr      <= '0;
      fin       <= 1'b0;
      run_cnt   <= 2'd0;
      idx       <= 5'd0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= 32'd0;
      out_valid <= 1'b0;
      out_data  <= 32'd0;
      out_last  <= 1'b0;
      err       <= 1'b0;
    end else begin
      mem_we <= acc;
      if (acc) begin
        mem_addr  <= waddr;
        mem_wdata <= in_data;
        addr      <= waddr + 1'b1;
        fin       <= wr_end;
        err       <= ((state == IDLE) ? 1'b0 : err) | ((waddr == ADDR_MAX) && !in_last);
      end
      if (state == START) fin <= 1'b0;

      if (state != RUN)         run_cnt <= 2'd0;
      else if (run_cnt != 2'd2) run_cnt <= run_cnt + 2'd1;

      // Each word is captured in the cycle after the previous handshake, so reg_addr has settled.
      if (state == DUMP) begin
        if (!out_valid) begin
          out_valid <= 1'b1;
          out_data  <= reg_rdata;
          out_last  <= (idx == LAST_IDX);
        end else if (out_ready) begin
          out_valid <= 1'b0;
          out_last  <= 1'b0;
          idx       <= out_last ? 5'd0 : idx + 5'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mips_prog_loader.sv
// Scoreboard bench for mips_prog_loader: drivers push expected writes/dump words, monitors pop and compare.
module tb_mips_prog_loader;

  logic        clk1 = 1'b0;
  logic        rst  = 1'b1;
  always #5 clk1 = ~clk1;

  logic        in_valid = 1'b0, in_last = 1'b0, in_ready;
  logic [31:0] in_data  = 32'd0;
  logic        mem_we, cpu_start, out_valid, out_last, busy, err;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata, reg_rdata, out_data;
  logic [4:0]  reg_addr;
  logic        cpu_halted = 1'b0;
  logic        out_ready  = 1'b1;
  logic [31:0] regs [32];
  assign reg_rdata = regs[reg_addr];

  logic        in_valid2 = 1'b0, in_last2 = 1'b0, in_ready2;
  logic [31:0] in_data2  = 32'd0;
  logic        mem_we2, cpu_start2, out_valid2, out_last2, busy2, err2;
  logic [1:0]  mem_addr2;
  logic [31:0] mem_wdata2, reg_rdata2, out_data2;
  logic [4:0]  reg_addr2;
  assign reg_rdata2 = {27'd0, reg_addr2};

  mips_prog_loader dut (
    .clk1(clk1), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_start(cpu_start), .cpu_halted(cpu_halted), .reg_addr(reg_addr), .reg_rdata(reg_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .busy(busy), .err(err)
  );

  mips_prog_loader #(.ADDR_W(2), .DUMP_N(6)) dut2 (
    .clk1(clk1), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2), .in_data(in_data2),
    .in_last(in_last2), .mem_we(mem_we2), .mem_addr(mem_addr2), .mem_wdata(mem_wdata2),
    .cpu_start(cpu_start2), .cpu_halted(1'b0), .reg_addr(reg_addr2), .reg_rdata(reg_rdata2),
    .out_valid(out_valid2), .out_ready(1'b1), .out_data(out_data2), .out_last(out_last2),
    .busy(busy2), .err(err2)
  );

  int n_cmp = 0, n_bad = 0;
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  logic [41:0] wq  [$];
  logic [33:0] wq2 [$];
  logic [32:0] dq  [$];
  logic [41:0] we_e;
  logic [33:0] we_e2;
  logic [32:0] dq_e;

  logic [31:0] prog [9] = '{32'h2801000a, 32'h28020014, 32'h28030019, 32'h0ce77800, 32'h0ce77800,
                            32'h00222000, 32'h0ce77800, 32'h00832800, 32'hfc000000};
  logic [31:0] exp_dump [6] = '{32'd0, 32'd10, 32'd20, 32'd25, 32'd30, 32'd55};

  int n_start = 0, n_start2 = 0, dump_cnt = 0;
  int stall_idx = -1, stall_left = 0;
  int cpu_hold = 0, cpu_delay = 3, cpu_cnt = 0;
  int lat_cnt = 0, lat_arm = 0, lat_meas = -1;
  logic prev_start = 1'b0, hold_pending = 1'b0, held_last = 1'b0;
  logic [31:0] held_data = 32'd0;

  always @(negedge clk1) begin
    if (!rst && mem_we) begin
      if (wq.size() == 0) check("mem_we_unexpected", 1, 0);
      else begin
        we_e = wq.pop_front();
        check("mem_addr", mem_addr, we_e[41:32]);
        check("mem_wdata", mem_wdata, we_e[31:0]);
      end
    end
    if (cpu_start) begin
      n_start++;
      check("start_after_writes", mem_we, 0);
      check("start_one_cycle", prev_start, 0);
    end
    prev_start = cpu_start;
  end

  always @(negedge clk1) begin
    if (!rst && mem_we2) begin
      if (wq2.size() == 0) check("ow_mem_we_unexpected", 1, 0);
      else begin
        we_e2 = wq2.pop_front();
        check("ow_mem_addr", mem_addr2, we_e2[33:32]);
        check("ow_mem_wdata", mem_wdata2, we_e2[31:0]);
      end
    end
    if (cpu_start2) n_start2++;
  end

  always @(negedge clk1) begin
    if (rst) hold_pending = 1'b0;
    else begin
      if (hold_pending) begin
        check("hold_valid", out_valid, 1);
        check("hold_data", out_data, held_data);
        check("hold_last", out_last, held_last);
      end
      hold_pending = out_valid && !out_ready;
      held_data = out_data;
      held_last = out_last;
      if (out_valid && out_ready) begin
        if (dq.size() == 0) check("dump_unexpected", 1, 0);
        else begin
          dq_e = dq.pop_front();
          check("dump_data", out_data, dq_e[31:0]);
          check("dump_last", out_last, dq_e[32]);
        end
        dump_cnt++;
      end
    end
  end

  always @(negedge clk1) begin
    if (cpu_start) begin lat_cnt = 0; lat_arm = 1; end
    else if (lat_arm != 0) begin
      lat_cnt++;
      if (out_valid) begin lat_meas = lat_cnt; lat_arm = 0; end
    end
  end

  // CPU stand-in: halts cpu_delay cycles after start, or stays halted when cpu_hold is set.
  always @(negedge clk1) begin
    #1;
    if (cpu_start) begin
      cpu_halted = (cpu_hold != 0);
      cpu_cnt = cpu_delay;
    end else if (cpu_cnt > 0) begin
      cpu_cnt--;
      if (cpu_cnt == 0) cpu_halted = 1'b1;
    end
  end

  always @(posedge clk1) begin
    #1;
    if (out_valid && dump_cnt == stall_idx && stall_left > 0) begin
      out_ready = 1'b0;
      stall_left--;
    end else out_ready = 1'b1;
  end

  task automatic send_word(input logic [31:0] d, input logic l, input int idx);
    int t = 0;
    in_valid = 1'b1; in_data = d; in_last = l;
    while (!in_ready && t < 50) begin @(negedge clk1); #1; t++; end
    if (!in_ready) check("accept_timeout", 0, 1);
    else wq.push_back({10'(idx), d});
    @(negedge clk1); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, in_ready, 1);
    check({tag, "_mem_we"}, mem_we, 0);
    check({tag, "_mem_addr"}, mem_addr, 0);
    check({tag, "_mem_wdata"}, mem_wdata, 0);
    check({tag, "_cpu_start"}, cpu_start, 0);
    check({tag, "_reg_addr"}, reg_addr, 0);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_out_data"}, out_data, 0);
    check({tag, "_out_last"}, out_last, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_err"}, err, 0);
  endtask

  task automatic run_prog(input int gap, input int hold, input int delay, input int stall,
                          input int abort, input int exp_lat);
    int base, st0, t;
    base = dump_cnt; st0 = n_start;
    cpu_hold = hold; cpu_delay = delay;
    if (hold != 0) cpu_halted = 1'b1;
    stall_idx  = (stall != 0) ? base + 3 : -1;
    stall_left = (stall != 0) ? 5 : 0;
    lat_meas = -1;
    for (int i = 0; i < 6; i++) dq.push_back({(i == 5), exp_dump[i]});
    for (int i = 0; i < 9; i++) begin
      if (gap != 0 && i > 0) begin @(negedge clk1); #1; end
      send_word(prog[i], (i == 8), i);
    end
    if (abort != 0) begin
      t = 0;
      while (dump_cnt < base + 3 && t < 400) begin @(negedge clk1); #1; t++; end
      check("abort_reached_dump", (dump_cnt >= base + 3), 1);
      @(posedge clk1); #1;
      rst = 1'b1;
      #1;
      check_reset_outputs("abort_rst");
      dq.delete();
      @(negedge clk1); #1;
      rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
        @(negedge clk1); #1;
        check("abort_no_out_valid", out_valid, 0);
      end
      check("abort_one_start", n_start - st0, 1);
      check("abort_wq_empty", wq.size(), 0);
    end else begin
      t = 0;
      do begin @(negedge clk1); #1; t++; end while (!(dq.size() == 0 && !busy) && t < 400);
      check("dump_complete", dq.size(), 0);
      check("wq_empty", wq.size(), 0);
      check("busy_idle", busy, 0);
      check("err_clear", err, 0);
      check("one_start", n_start - st0, 1);
      if (exp_lat > 0) check("run_latency", lat_meas, exp_lat);
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = 32'd0;
    regs[1] = 32'd10; regs[2] = 32'd20; regs[3] = 32'd25; regs[4] = 32'd30; regs[5] = 32'd55;
    repeat (3) @(negedge clk1);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk1); #1;

    // Overflow on the 2-bit address instance: four writes, err, start, fifth word refused.
    for (int i = 0; i < 4; i++) begin
      in_valid2 = 1'b1; in_data2 = 32'h11110000 + i; in_last2 = 1'b0;
      check("ow_ready", in_ready2, 1);
      wq2.push_back({2'(i), 32'h11110000 + i});
      @(negedge clk1); #1;
    end
    in_data2 = 32'h11110004;
    for (int i = 0; i < 8; i++) begin
      check("ow_no_accept", in_ready2, 0);
      @(negedge clk1); #1;
    end
    in_valid2 = 1'b0;
    check("ow_err", err2, 1);
    check("ow_one_start", n_start2, 1);
    check("ow_writes_done", wq2.size(), 0);
    check("ow_busy_run", busy2, 1);

    run_prog(0, 0, 3, 0, 0, 0);
    run_prog(1, 0, 3, 0, 0, 0);
    run_prog(0, 0, 3, 1, 0, 0);
    run_prog(0, 1, 0, 0, 0, 5);
    run_prog(0, 0, 20, 0, 0, 22);
    run_prog(0, 0, 3, 0, 1, 0);
    run_prog(0, 0, 3, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    n_bad++;
    $display("FAIL global_timeout: got running, expected finished");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1);
  end

endmodule
